// File: rtl/fft_pkg.sv
// Shared fixed-point helpers for the FFT stage blocks: default widths,
// complex packing, round-half-up shifting and saturation on a wide accumulator.
package fft_pkg;

  localparam int DW_DEF  = 16;
  localparam int FW_DEF  = 8;
  localparam int TWW_DEF = 16;
  localparam int ACC_W   = 64;

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;

  function automatic cplx_t cplx_unpack(input logic [2*DW_DEF-1:0] w);
    cplx_t c;
    c.re = w[2*DW_DEF-1:DW_DEF];
    c.im = w[DW_DEF-1:0];
    return c;
  endfunction

  function automatic logic [2*DW_DEF-1:0] cplx_pack(input cplx_t c);
    return {c.re, c.im};
  endfunction

  // Add one at the first dropped bit, then arithmetic shift.
  function automatic acc_t round_shift(input acc_t x, input int sh);
    acc_t half;
    if (sh <= 0) return x;
    half = acc_t'(1) <<< (sh - 1);
    return (x + half) >>> sh;
  endfunction

  function automatic acc_t sat(input acc_t x, input int w);
    acc_t hi;
    acc_t lo;
    hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    lo = -(acc_t'(1) <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic sat_hit(input acc_t x, input int w);
    acc_t hi;
    acc_t lo;
    hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    lo = -(acc_t'(1) <<< (w - 1));
    return (x > hi) || (x < lo);
  endfunction

endpackage

// File: rtl/fft_bfly_pe_param_twiddle_rom.sv
// Twiddle ROM for k in [0, N/2): registered {cos, sin} in Q2.(TWW-2),
// table built at elaboration and rounded to nearest.
module fft_twiddle_rom
  import fft_pkg::*;
#(
  parameter int LOG2N = 4,
  parameter int TWW   = TWW_DEF
) (
  input  logic               clk,
  input  logic [LOG2N-2:0]   addr,
  output logic [2*TWW-1:0]   tw
);

  localparam int  N   = 1 << LOG2N;
  localparam int  NH  = 1 << (LOG2N - 1);
  localparam int  ONE = 1 << (TWW - 2);
  localparam real PI  = 3.14159265358979323846;

  function automatic logic signed [TWW-1:0] tw_entry(input int k, input bit use_sin);
    real ang;
    real v;
    ang = 2.0 * PI * real'(k) / real'(N);
    v   = (use_sin ? $sin(ang) : $cos(ang)) * real'(ONE);
    if (v >= 0.0) return TWW'($rtoi(v + 0.5));
    return TWW'(-$rtoi(0.5 - v));
  endfunction

  logic signed [TWW-1:0] cos_tab [NH];
  logic signed [TWW-1:0] sin_tab [NH];

  for (genvar k = 0; k < NH; k++) begin : g_tab
    localparam logic signed [TWW-1:0] COS_V = tw_entry(k, 1'b0);
    localparam logic signed [TWW-1:0] SIN_V = tw_entry(k, 1'b1);
    assign cos_tab[k] = COS_V;
    assign sin_tab[k] = SIN_V;
  end

  always_ff @(posedge clk) begin
    tw <= {cos_tab[addr], sin_tab[addr]};
  end

endmodule

// File: rtl/fft_bfly_pe_param.sv
// Parametrised radix-2 DIF butterfly PE: fft_a = a+b, fft_b = (a-b)*W_N^k,
// with inverse twiddle, optional 1/2 scaling, saturation and a stallable 3-stage pipe.
module fft_bfly_pe_param
  import fft_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int FW    = FW_DEF,
  parameter int LOG2N = 4,
  parameter int TWW   = TWW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2*DW-1:0]   a,
  input  logic [2*DW-1:0]   b,
  input  logic [LOG2N-2:0]  power,
  input  logic              inverse,
  input  logic              scale,
  input  logic              ab_valid,
  output logic              ab_ready,
  output logic [2*DW-1:0]   fft_a,
  output logic [2*DW-1:0]   fft_b,
  output logic              fft_pe_valid,
  input  logic              fft_ready,
  output logic              ovf,
  input  logic              clr_ovf
);

  localparam int SW = DW + 1;
  localparam int PW = DW + 1 + TWW;
  localparam int CW = PW + 1;

  if (FW < 0 || FW >= DW) begin : g_fw_check
    $error("FW must lie in [0, DW)");
  end

  logic adv;
  logic vld_p1, vld_p2, vld_p3;
  logic sat_p3;

  assign adv          = !vld_p3 | fft_ready;
  assign ab_ready     = adv;
  assign fft_pe_valid = vld_p3;

  logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  assign a_re = a[2*DW-1:DW];
  assign a_im = a[DW-1:0];
  assign b_re = b[2*DW-1:DW];
  assign b_im = b[DW-1:0];

  // ---- S1: sum/diff at DW+1 bits ----
  logic signed [SW-1:0] sum_re_p1, sum_im_p1, dif_re_p1, dif_im_p1;
  logic [LOG2N-2:0]     power_p1;
  logic                 inv_p1, scale_p1;

  // While stalled the ROM re-reads the S1 index so its output stays aligned with S1.
  logic [LOG2N-2:0]   rom_addr;
  logic [2*TWW-1:0]   tw;
  assign rom_addr = adv ? power : power_p1;

  fft_twiddle_rom #(
    .LOG2N (LOG2N),
    .TWW   (TWW)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .tw   (tw)
  );

  logic signed [TWW-1:0] tw_cos, tw_sin, tw_sin_eff;
  assign tw_cos     = tw[2*TWW-1:TWW];
  assign tw_sin     = tw[TWW-1:0];
  assign tw_sin_eff = inv_p1 ? -tw_sin : tw_sin;

  // ---- S2: four partial products ----
  logic signed [PW-1:0] prod_rc_p2, prod_is_p2, prod_ic_p2, prod_rs_p2;
  logic signed [SW-1:0] sum_re_p2, sum_im_p2;
  logic                 scale_p2;

  always_ff @(posedge clk) begin
    if (adv) begin
      sum_re_p1  <= SW'(a_re) + SW'(b_re);
      sum_im_p1  <= SW'(a_im) + SW'(b_im);
      dif_re_p1  <= SW'(a_re) - SW'(b_re);
      dif_im_p1  <= SW'(a_im) - SW'(b_im);
      power_p1   <= power;
      inv_p1     <= inverse;
      scale_p1   <= scale;

      prod_rc_p2 <= PW'(dif_re_p1) * PW'(tw_cos);
      prod_is_p2 <= PW'(dif_im_p1) * PW'(tw_sin_eff);
      prod_ic_p2 <= PW'(dif_im_p1) * PW'(tw_cos);
      prod_rs_p2 <= PW'(dif_re_p1) * PW'(tw_sin_eff);
      sum_re_p2  <= sum_re_p1;
      sum_im_p2  <= sum_im_p1;
      scale_p2   <= scale_p1;
    end
  end

  // ---- S3: combine, round, saturate ----
  // (dr + j di)(c - j s) = (dr c + di s) + j(di c - dr s); inverse flips s.
  logic signed [CW-1:0] b_re_acc, b_im_acc;
  acc_t                 a_re_r, a_im_r, b_re_r, b_im_r;
  logic signed [DW-1:0] fa_re, fa_im, fb_re, fb_im;
  logic                 hit;

  always_comb begin
    b_re_acc = CW'(prod_rc_p2) + CW'(prod_is_p2);
    b_im_acc = CW'(prod_ic_p2) - CW'(prod_rs_p2);
    a_re_r   = round_shift(acc_t'(sum_re_p2), int'(scale_p2));
    a_im_r   = round_shift(acc_t'(sum_im_p2), int'(scale_p2));
    b_re_r   = round_shift(acc_t'(b_re_acc), TWW - 2 + int'(scale_p2));
    b_im_r   = round_shift(acc_t'(b_im_acc), TWW - 2 + int'(scale_p2));
    hit      = sat_hit(a_re_r, DW) | sat_hit(a_im_r, DW) |
               sat_hit(b_re_r, DW) | sat_hit(b_im_r, DW);
    fa_re    = DW'(sat(a_re_r, DW));
    fa_im    = DW'(sat(a_im_r, DW));
    fb_re    = DW'(sat(b_re_r, DW));
    fb_im    = DW'(sat(b_im_r, DW));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      sat_p3 <= 1'b0;
      fft_a  <= '0;
      fft_b  <= '0;
    end else if (adv) begin
      vld_p1 <= ab_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      sat_p3 <= vld_p2 & hit;
      fft_a  <= {fa_re, fa_im};
      fft_b  <= {fb_re, fb_im};
    end
  end

  // Sticky flag updates only when a saturated result actually leaves the PE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (vld_p3 && fft_ready && sat_p3) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_bfly_pe_param.sv
// Directed bench for fft_bfly_pe_param at default parameters (Q8.8, N=16).
module tb_fft_bfly_pe_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_in, b_in;
  logic [2:0]  power;
  logic        inverse, scale, ab_valid, fft_ready, clr_ovf;
  logic        ab_ready, fft_pe_valid, ovf;
  logic [31:0] fft_a, fft_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fft_bfly_pe_param dut (
    .clk          (clk),
    .rst          (rst),
    .a            (a_in),
    .b            (b_in),
    .power        (power),
    .inverse      (inverse),
    .scale        (scale),
    .ab_valid     (ab_valid),
    .ab_ready     (ab_ready),
    .fft_a        (fft_a),
    .fft_b        (fft_b),
    .fft_pe_valid (fft_pe_valid),
    .fft_ready    (fft_ready),
    .ovf          (ovf),
    .clr_ovf      (clr_ovf)
  );

  function automatic bit near(input logic [31:0] x, input logic [31:0] y);
    int dr, di;
    dr = int'($signed(x[31:16])) - int'($signed(y[31:16]));
    di = int'($signed(x[15:0]))  - int'($signed(y[15:0]));
    return (dr >= -1) && (dr <= 1) && (di >= -1) && (di <= 1);
  endfunction

  // Presents one pair, waits (bounded) for its result and lets it transfer.
  task automatic send_one(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] k,
                          input logic inv, input logic scl,
                          output logic [31:0] oa, output logic [31:0] ob, output int lat);
    a_in = ta; b_in = tb; power = k; inverse = inv; scale = scl;
    ab_valid = 1'b1; fft_ready = 1'b1;
    @(posedge clk); #1;
    ab_valid = 1'b0;
    lat = 1;
    while (!fft_pe_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    oa = fft_a; ob = fft_b;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_tests++; if (fft_pe_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", fft_pe_valid); end
    n_tests++; if (fft_a !== 32'h0) begin n_fail++; $display("FAIL reset_fft_a got %h want 0", fft_a); end
    n_tests++; if (fft_b !== 32'h0) begin n_fail++; $display("FAIL reset_fft_b got %h want 0", fft_b); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
    n_tests++; if (ab_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ab_ready got %b want 1", ab_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] oa, ob; int lat;
    send_one(32'h0100_0000, 32'h0080_0000, 3'd0, 1'b0, 1'b0, oa, ob, lat);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency got %0d want 3", lat); end
    n_tests++; if (oa !== 32'h0180_0000) begin n_fail++; $display("FAIL basic_fft_a got %h want 01800000", oa); end
    n_tests++; if (ob !== 32'h0080_0000) begin n_fail++; $display("FAIL basic_fft_b got %h want 00800000", ob); end
  endtask

  task automatic test_twiddle_j();
    logic [31:0] oa, ob; int lat;
    send_one(32'h0100_0000, 32'h0080_0000, 3'd4, 1'b0, 1'b0, oa, ob, lat);
    n_tests++; if (!near(ob, 32'h0000_FF80)) begin n_fail++; $display("FAIL k4_fwd_fft_b got %h want 0000ff80", ob); end
    send_one(32'h0100_0000, 32'h0080_0000, 3'd4, 1'b1, 1'b0, oa, ob, lat);
    n_tests++; if (!near(ob, 32'h0000_0080)) begin n_fail++; $display("FAIL k4_inv_fft_b got %h want 00000080", ob); end
    n_tests++; if (oa !== 32'h0180_0000) begin n_fail++; $display("FAIL k4_inv_fft_a got %h want 01800000", oa); end
  endtask

  task automatic test_saturation();
    logic [31:0] oa, ob; int lat;
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL sat_ovf_pre got %b want 0", ovf); end
    send_one(32'h7F00_0000, 32'h7F00_0000, 3'd0, 1'b0, 1'b0, oa, ob, lat);
    n_tests++; if (oa !== 32'h7FFF_0000) begin n_fail++; $display("FAIL sat_pos_fft_a got %h want 7fff0000", oa); end
    n_tests++; if (ob !== 32'h0) begin n_fail++; $display("FAIL sat_pos_fft_b got %h want 0", ob); end
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf_set got %b want 1", ovf); end
    clr_ovf = 1'b1; @(posedge clk); #1; clr_ovf = 1'b0;
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL sat_ovf_clr got %b want 0", ovf); end
    send_one(32'h7F00_0000, 32'h7F00_0000, 3'd0, 1'b0, 1'b1, oa, ob, lat);
    n_tests++; if (oa !== 32'h7F00_0000) begin n_fail++; $display("FAIL scale_fft_a got %h want 7f000000", oa); end
    n_tests++; if (ob !== 32'h0) begin n_fail++; $display("FAIL scale_fft_b got %h want 0", ob); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL scale_ovf got %b want 0", ovf); end
    send_one(32'h8000_8000, 32'h8000_8000, 3'd0, 1'b0, 1'b0, oa, ob, lat);
    n_tests++; if (oa !== 32'h8000_8000) begin n_fail++; $display("FAIL sat_neg_fft_a got %h want 80008000", oa); end
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL sat_neg_ovf got %b want 1", ovf); end
    clr_ovf = 1'b1; @(posedge clk); #1; clr_ovf = 1'b0;
  endtask

  task automatic test_twiddle_sweep();
    int cre [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
    int cim [8] = '{0, -98, -181, -237, -256, -237, -181, -98};
    logic [31:0] oa, ob, exp_b; int lat;
    for (int k = 0; k < 8; k++) begin
      send_one(32'h0100_0000, 32'h0, 3'(k), 1'b0, 1'b0, oa, ob, lat);
      exp_b = {16'(cre[k]), 16'(cim[k])};
      n_tests++;
      if (!near(ob, exp_b)) begin n_fail++; $display("FAIL sweep_k%0d_fft_b got %h want %h", k, ob, exp_b); end
    end
    n_tests++; if (oa !== 32'h0100_0000) begin n_fail++; $display("FAIL sweep_fft_a got %h want 01000000", oa); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ia [16], ib [16], ea [16], eb [16];
    logic [2:0]  ik [16];
    logic [31:0] pa, pb;
    int in_idx, out_idx;
    bit prev_stall;
    for (int i = 0; i < 16; i++) begin
      int are, aim, bre, bim, dre, dim;
      are = i * 64 + 16; aim = -(i * 8); bre = i * 16; bim = i * 24 - 100;
      dre = are - bre;   dim = aim - bim;
      ia[i] = {16'(are), 16'(aim)};
      ib[i] = {16'(bre), 16'(bim)};
      ik[i] = (i % 2 == 1) ? 3'd4 : 3'd0;
      ea[i] = {16'(are + bre), 16'(aim + bim)};
      eb[i] = (i % 2 == 1) ? {16'(dim), 16'(-dre)} : {16'(dre), 16'(dim)};
    end
    in_idx = 0; out_idx = 0; prev_stall = 0; pa = '0; pb = '0;
    for (int c = 0; c < 80 && out_idx < 16; c++) begin
      fft_ready = !(c >= 4 && c <= 8);
      inverse = 1'b0; scale = 1'b0;
      if (in_idx < 16) begin
        a_in = ia[in_idx]; b_in = ib[in_idx]; power = ik[in_idx]; ab_valid = 1'b1;
      end else begin
        ab_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        n_tests++;
        if (fft_pe_valid !== 1'b1 || fft_a !== pa || fft_b !== pb) begin
          n_fail++; $display("FAIL stall_hold c%0d got v=%b %h %h want v=1 %h %h", c, fft_pe_valid, fft_a, fft_b, pa, pb);
        end
      end
      if (fft_pe_valid && !fft_ready) begin
        n_tests++;
        if (ab_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ab_ready c%0d got %b want 0", c, ab_ready); end
        pa = fft_a; pb = fft_b; prev_stall = 1;
      end else begin
        prev_stall = 0;
      end
      if (fft_pe_valid && fft_ready) begin
        n_tests++;
        if (fft_a !== ea[out_idx] || fft_b !== eb[out_idx]) begin
          n_fail++; $display("FAIL stream_item%0d got %h %h want %h %h", out_idx, fft_a, fft_b, ea[out_idx], eb[out_idx]);
        end
        out_idx++;
      end
      if (ab_valid && ab_ready) in_idx++;
      @(posedge clk); #1;
    end
    ab_valid = 1'b0; fft_ready = 1'b1;
    n_tests++; if (out_idx !== 16) begin n_fail++; $display("FAIL stream_count got %0d want 16", out_idx); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] oa, ob; int lat;
    send_one(32'h7F00_0000, 32'h7F00_0000, 3'd0, 1'b0, 1'b0, oa, ob, lat);
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL rstmid_ovf_pre got %b want 1", ovf); end
    a_in = 32'h1000_0000; b_in = 32'h0; power = 3'd0; ab_valid = 1'b1; fft_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ab_valid = 1'b0;
    rst = 1'b1; #1;
    n_tests++; if (fft_pe_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", fft_pe_valid); end
    n_tests++; if (fft_a !== 32'h0 || fft_b !== 32'h0) begin n_fail++; $display("FAIL rstmid_outputs got %h %h want 0 0", fft_a, fft_b); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf got %b want 0", ovf); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_one(32'h0200_0010, 32'h0100_0020, 3'd0, 1'b0, 1'b0, oa, ob, lat);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL rstmid_latency got %0d want 3", lat); end
    n_tests++; if (oa !== 32'h0300_0030) begin n_fail++; $display("FAIL rstmid_fft_a got %h want 03000030", oa); end
    n_tests++; if (ob !== 32'h0100_FFF0) begin n_fail++; $display("FAIL rstmid_fft_b got %h want 0100fff0", ob); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; a_in = '0; b_in = '0; power = '0; inverse = 1'b0; scale = 1'b0;
    ab_valid = 1'b0; fft_ready = 1'b1; clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_twiddle_j();
    test_saturation();
    test_twiddle_sweep();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
